ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite subordinate that turns bus transfers into accesses on a single-port synchronous SRAM.
//  SRAM has active-low cen/wen/ben and 1-cycle read latency.
//  It is the responder side of the core's AHB-Lite manager port (HADDR/HTRANS/HWRITE/HSIZE/HWDATA).
//  Sits behind the system decoder (HSEL) and gives synthesizable data memory in place of the behavioural bench memory.
// PARAMETERS
//  ADDR_W    32     HADDR width
//  MEM_BYTES 2**16  SRAM size in bytes (power of 2); sram_addr = HADDR modulo MEM_BYTES
// PORTS
//  HCLK       in   1   bus clock; the only clock in the block
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select from the address decoder
//  HADDR      in   32  address-phase byte address
//  HTRANS     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   000 byte, 001 half, 010 word
//  HWDATA     in   32  write data, valid in the data phase
//  HREADY     in   1   bus-wide ready (mux output)
//  HRDATA     out  32  read data
//  HREADYOUT  out  1   this slave's ready
//  HRESP      out  1   0 OKAY, 1 ERROR
//  sram_cen   out  1   chip enable, active low
//  sram_wen   out  1   write enable, active low
//  sram_ben   out  4   byte enables, active low; bit i = byte lane i
//  sram_addr  out  32  byte address (the SRAM uses [..:2])
//  sram_din   out  32  SRAM write data
//  sram_dout  in   32  SRAM read data, valid the cycle after a cen=0, wen=1 access
// BEHAVIOUR
//  Reset (async, HRESETn=0): state S_IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, sram_cen=1, sram_wen=1, sram_ben=4'hF.
//    sram_cen is forced high combinationally while HRESETn=0.
//  Transfer accepted when HSEL & HREADY & HTRANS[1]. BUSY and IDLE get a zero-wait OKAY with no SRAM access.
//  Accept captures addr, size and write into data-phase registers.
//  Byte enables: ben = ~mask.
//    byte: mask 1<<a[1:0]; half: 2'b11<<{a[1],1'b0}; word: 4'hF.
//  FSM:
//    S_IDLE: idle data phase; HREADYOUT=1.
//    S_WRITE: write data phase; sram_cen=0, sram_wen=0, ben/addr from the registers, sram_din=HWDATA; HREADYOUT=1. Zero wait.
//    S_READ: read accepted with the SRAM free. The SRAM read is issued combinationally in the address phase from HADDR.
//      In the data phase HRDATA=sram_dout and HREADYOUT=1. Zero wait.
//    S_RD_WAIT: read accepted while in S_WRITE (port busy).
//      Cycle 1: issue the read from the registered addr, HREADYOUT=0.
//      Cycle 2: go to S_READ timing, HRDATA=sram_dout, HREADYOUT=1. One wait state.
//    S_ERR1 / S_ERR2: see CONFIGURATION.
//  Transitions on each HREADY=1 cycle come from the accepted transfer: write->S_WRITE; read->S_READ or S_RD_WAIT; none->S_IDLE.
//  While HREADY=0 (any slave stalling) no new transfer is captured and no address-phase SRAM read is issued.
//  Back-to-back:
//    W,W  both zero wait.
//    R,W  both zero wait (read issued in address phase, write in the next cycle).
//    W,R  read takes one wait.
//  Read of an address written in the previous cycle returns the new data (the read is deferred past the write).
//  HRDATA is 0 outside a read data phase. Sub-word reads return the full word; the manager selects the lanes.
//  HSIZE > 010 is treated as word.
// CONFIGURATION
//  AHB_SRAM_ERR_EN defined:
//    Accepted transfers that are misaligned (half with a[0]=1, word with a[1:0]!=0) or have HADDR >= MEM_BYTES
//    get the 2-cycle AHB ERROR response and no SRAM access.
//    S_ERR1: HREADYOUT=0, HRESP=1. S_ERR2: HREADYOUT=1, HRESP=1.
//    A transfer presented during S_ERR2 is accepted normally.
//  AHB_SRAM_ERR_EN undefined:
//    HRESP is tied 0. HADDR wraps modulo MEM_BYTES. Misaligned low address bits are ignored for ben (word/half lane taken as aligned).
// STRUCTURE
//  types package: htrans_t enum, HSIZE_BYTE/HALF/WORD constants, ahb_sram_state_t {S_IDLE,S_WRITE,S_READ,S_RD_WAIT,S_ERR1,S_ERR2}.
//  Sub-module ahb_ben_decode: combinational (addr[1:0], hsize) -> ben[3:0], plus an align_err flag.
// TESTING
//  Write word 0xDEADBEEF @0x10, then read @0x10 -> HRDATA=0xDEADBEEF, zero wait.
//  Byte writes 0x11,0x22,0x33,0x44 @0x20..0x23, read word @0x20 -> 0x44332211; sram_ben 4'hE,D,B,7.
//  W@0x30=0x5 immediately followed by R@0x30 -> exactly one HREADYOUT=0 cycle, HRDATA=0x5.
//  Read burst of 4 SEQ words @0x40 after preloading 1..4 -> 1,2,3,4 on consecutive cycles, no waits.
//  HRESETn low mid-write data phase -> sram_cen=1 within the same cycle, HREADYOUT=1, state S_IDLE.
//  ERR_EN: word read @0x2 -> HREADYOUT 0 then 1 with HRESP=1 both cycles, sram_cen stays 1.
//    Without ERR_EN: HRESP=0 and the word @0x0 is returned.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared types for the AHB-Lite SRAM subordinate: transfer types, size codes
// and the data-phase state encoding.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RD_WAIT,
    S_ERR1,
    S_ERR2
  } ahb_sram_state_t;

  // Only NONSEQ and SEQ carry real data; IDLE and BUSY never touch the SRAM.
  function automatic logic isActive(htrans_t trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// Bus bundle between an AHB-Lite manager, this SRAM subordinate and the SRAM macro.
// The slave modport is the subordinate's view; master is the manager/SRAM side.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32
);

  logic                          HSEL;
  logic [ADDR_W-1:0]             HADDR;
  ahb_sram_slave_pkg::htrans_t   HTRANS;
  logic                          HWRITE;
  logic [2:0]                    HSIZE;
  logic [31:0]                   HWDATA;
  logic                          HREADY;
  logic [31:0]                   HRDATA;
  logic                          HREADYOUT;
  logic                          HRESP;

  logic                          sram_cen;
  logic                          sram_wen;
  logic [3:0]                    sram_ben;
  logic [ADDR_W-1:0]             sram_addr;
  logic [31:0]                   sram_din;
  logic [31:0]                   sram_dout;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_dout,
    output HRDATA, HREADYOUT, HRESP, sram_cen, sram_wen, sram_ben, sram_addr, sram_din
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_dout,
    input  HRDATA, HREADYOUT, HRESP, sram_cen, sram_wen, sram_ben, sram_addr, sram_din
  );

endinterface

// File: rtl/ahb_sram_slave_ben_decode.sv
// Byte-lane decoder: turns the low address bits and HSIZE into active-low
// SRAM byte enables and flags transfers that are not naturally aligned.
// Sizes above a word are handled as a word.
module ahb_ben_decode
  import ahb_sram_slave_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] hsize_i,
  output logic [3:0] ben_o,
  output logic       alignErr_o
);

  logic [3:0] laneMask;

  // Select the active lanes; a[0] is ignored for halves and a[1:0] for words,
  // so a misaligned access still maps onto an aligned lane group.
  always_comb begin
    laneMask   = 4'hF;
    alignErr_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: laneMask = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        laneMask   = 4'b0011 << {addr_i[1], 1'b0};
        alignErr_o = addr_i[0];
      end
      default: begin
        laneMask   = 4'hF;
        alignErr_o = |addr_i;
      end
    endcase
    ben_o = ~laneMask;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate fronting a single-port synchronous SRAM (1-cycle read).
// Reads are issued in the address phase so they are zero-wait; a read that
// follows a write is pushed one cycle past the write and costs one wait state.
// Optional macro AHB_SRAM_ERR_EN: misaligned or out-of-range transfers get the
// two-cycle ERROR response instead of wrapping.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 2**16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_sram_slave_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

  ahb_sram_state_t   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        ben_q, ben_d;

  logic              accept;
  logic              accErr;
  logic              addrPhaseRead;
  logic              alignErr;
  logic [3:0]        benDec;
  logic [ADDR_W-1:0] haddrWrapped;

  assign haddrWrapped = bus.HADDR & ADDR_MASK;
  assign accept       = bus.HSEL & bus.HREADY & isActive(bus.HTRANS);

  ahb_ben_decode uBenDecode (
    .addr_i     (bus.HADDR[1:0]),
    .hsize_i    (bus.HSIZE),
    .ben_o      (benDec),
    .alignErr_o (alignErr)
  );

`ifdef AHB_SRAM_ERR_EN
  assign accErr = accept & (alignErr | (|(bus.HADDR & ~ADDR_MASK)));
`else
  logic unusedAlignErr;
  assign unusedAlignErr = alignErr;
  assign accErr         = 1'b0;
`endif

  // The port is busy with a write in S_WRITE, so a read accepted then waits.
  assign addrPhaseRead = accept & ~bus.HWRITE & ~accErr & (state_q != S_WRITE);

  // Data-phase register: state plus the captured address and lane enables.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ben_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
    end
  end

  // Next state: self-timed wait/error cycles advance alone, otherwise follow the accepted transfer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ben_d   = ben_q;
    case (state_q)
      S_RD_WAIT: state_d = S_READ;
      S_ERR1:    state_d = S_ERR2;
      default: begin
        if (bus.HREADY) begin
          if (!accept) begin
            state_d = S_IDLE;
          end else if (accErr) begin
            state_d = S_ERR1;
          end else begin
            addr_d = haddrWrapped;
            ben_d  = benDec;
            if (bus.HWRITE)             state_d = S_WRITE;
            else if (state_q == S_WRITE) state_d = S_RD_WAIT;
            else                        state_d = S_READ;
          end
        end
      end
    endcase
  end

  // Bus response and SRAM strobes; the chip enable is held off whenever reset is asserted.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;
    bus.sram_cen  = 1'b1;
    bus.sram_wen  = 1'b1;
    bus.sram_ben  = 4'hF;
    bus.sram_addr = addr_q;
    bus.sram_din  = bus.HWDATA;
    case (state_q)
      S_WRITE: begin
        bus.sram_cen = 1'b0;
        bus.sram_wen = 1'b0;
        bus.sram_ben = ben_q;
      end
      S_READ: bus.HRDATA = bus.sram_dout;
      S_RD_WAIT: begin
        bus.sram_cen  = 1'b0;
        bus.sram_ben  = 4'h0;
        bus.HREADYOUT = 1'b0;
      end
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      S_ERR2: bus.HRESP = 1'b1;
`endif
      default: ;
    endcase
    if (addrPhaseRead) begin
      bus.sram_cen  = 1'b0;
      bus.sram_wen  = 1'b1;
      bus.sram_ben  = 4'h0;
      bus.sram_addr = haddrWrapped;
    end
    if (!HRESETn) begin
      bus.sram_cen = 1'b1;
      bus.sram_wen = 1'b1;
      bus.sram_ben = 4'hF;
    end
  end

endmodule
